// File: rtl/vivo_pop_arbiter.sv
// Round-robin arbiter sharing the VIVO FIFO pop port between N_CONS consumers.
// The granted request is held on the FIFO until the pop handshake completes or times out.
module vivo_pop_arbiter #(
  parameter int ELEM_WIDTH    = 8,
  parameter int OUT_ELEMS_MAX = 4,
  parameter int N_CONS        = 4,
  parameter int WAIT_MAX      = 15,
  localparam int GW = $clog2(N_CONS),
  localparam int NW = $clog2(OUT_ELEMS_MAX + 1),
  localparam int DW = OUT_ELEMS_MAX * ELEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CONS-1:0]    cons_req_valid,
  input  logic [N_CONS*NW-1:0] cons_req_elems,
  output logic [N_CONS-1:0]    cons_resp_valid,
  input  logic [N_CONS-1:0]    cons_resp_ready,
  output logic [DW-1:0]        cons_resp_data,
  output logic [NW-1:0]        cons_resp_num,
  output logic [NW-1:0]        fifo_out_req_elems,
  input  logic                 fifo_out_valid,
  output logic                 fifo_out_ready,
  input  logic [DW-1:0]        fifo_out_data,
  input  logic [NW-1:0]        fifo_out_num_elems,
  output logic                 busy,
  output logic                 stat_timeout
);

  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, state_d;
  logic [GW-1:0] rr_ptr, rr_d;
  logic [GW-1:0] gnt, gnt_d;
  logic [NW-1:0] gnt_elems, gnt_elems_d;
  logic [CW-1:0] wait_cnt, wait_cnt_d;

  logic [N_CONS-1:0] eligible;
  logic              pick_found;
  logic [GW-1:0]     pick_idx;
  logic [NW-1:0]     pick_elems;
  logic [GW-1:0]     cand;
  logic [GW-1:0]     next_ptr;
  logic              expire;
  logic              pop;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < N_CONS; i++) begin
      eligible[i] = cons_req_valid[i]
                    && (cons_req_elems[i*NW +: NW] != '0)
                    && (cons_req_elems[i*NW +: NW] <= NW'(OUT_ELEMS_MAX));
    end
  end

  // Scan from rr_ptr upward (wrapping) and take the first eligible consumer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_elems = '0;
    cand       = '0;
    for (int k = 0; k < N_CONS; k++) begin
      cand = GW'((int'(rr_ptr) + k) % N_CONS);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
        pick_elems = cons_req_elems[cand*NW +: NW];
      end
    end
  end

  assign next_ptr = (gnt == GW'(N_CONS - 1)) ? '0 : gnt + 1'b1;

  // Request to the FIFO is combinational so an expiring grant withdraws it in the same cycle.
  always_comb begin
    state_d            = state;
    rr_d               = rr_ptr;
    gnt_d              = gnt;
    gnt_elems_d        = gnt_elems;
    wait_cnt_d         = wait_cnt;
    cons_resp_valid    = '0;
    cons_resp_data     = '0;
    cons_resp_num      = '0;
    fifo_out_req_elems = '0;
    fifo_out_ready     = 1'b0;
    busy               = 1'b0;
    stat_timeout       = 1'b0;
    expire             = 1'b0;
    pop                = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d       = pick_idx;
          gnt_elems_d = pick_elems;
          wait_cnt_d  = '0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy                 = 1'b1;
        expire               = (WAIT_MAX != 0) && (wait_cnt == CW'(WAIT_MAX)) && !fifo_out_valid;
        pop                  = fifo_out_valid && cons_resp_ready[gnt];
        fifo_out_req_elems   = expire ? '0 : gnt_elems;
        cons_resp_valid[gnt] = fifo_out_valid;
        cons_resp_data       = fifo_out_data;
        cons_resp_num        = fifo_out_num_elems;
        fifo_out_ready       = pop;
        if (pop || expire) begin
          stat_timeout = expire;
          rr_d         = next_ptr;
          state_d      = ST_IDLE;
        end else if (!fifo_out_valid && (wait_cnt != '1)) begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      gnt_elems <= '0;
      wait_cnt  <= '0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_d;
      gnt       <= gnt_d;
      gnt_elems <= gnt_elems_d;
      wait_cnt  <= wait_cnt_d;
    end
  end

endmodule
